wb_commit_queue: RTL
====================

// Module: wb_commit_queue
// PURPOSE
//  Parametrised writeback stage. It accepts completed instructions from MEM over a valid/ready handshake.
//  Each accepted instruction is formatted into its final register-file write (load extension, result
//  select, write-enable rules), then held in a DEPTH-entry in-order queue. Entries drain through a
//  register-file write port that can be back-pressured (the port is shared with CSR/debug writes).
//  Also provides a retire counter and a sticky misaligned-load error flag.
// PARAMETERS
//  XLEN    32  datapath width; 32 or 64 only
//  DEPTH   2   queue entries; power of 2, >=2
//  CNT_W   32  retire counter width
// PORTS
//  clk           in   1      clock; all state updates on rising edge
//  rst           in   1      synchronous, active-high reset
//  i_valid       in   1      MEM presents an instruction
//  o_ready       out  1      queue can accept; = (count < DEPTH); registered state only, no comb path from i_rf_ready
//  i_opcode      in   7      instruction opcode (`B, `S, `L, `JAL, `JALR, others)
//  i_funct3      in   3      load size/sign select
//  i_rd          in   5      destination register
//  i_alu_res     in   XLEN   ALU result
//  i_mem_rdata   in   XLEN   raw aligned memory word
//  i_byte_off    in   3      load address low bits; bit 2 is ignored when XLEN=32
//  i_pc_plus4    in   XLEN   link value for JAL/JALR
//  o_rf_wr       out  1      register-file write strobe (head valid & head we)
//  o_rf_waddr    out  5      head rd
//  o_rf_wdata    out  XLEN   head formatted data
//  i_rf_ready    in   1      write port available this cycle
//  o_retire_cnt  out  CNT_W  number of entries popped; wraps modulo 2^CNT_W
//  o_ld_err      out  1      sticky: a misaligned load was accepted
// BEHAVIOUR
//  Reset (rst=1 at edge): queue empty, count=0, rd/wr pointers=0, o_retire_cnt=0, o_ld_err=0.
//   Outputs during and after reset: o_ready=1 (count=0), o_rf_wr=0, o_rf_waddr=0, o_rf_wdata=0.
//   Reset mid-operation discards all queued entries; no write is issued for them.
//  Push: i_valid & o_ready. The entry {we, rd, data} is formatted combinationally from the inputs and
//   stored at the push edge.
//  Pop: head valid & (i_rf_ready | ~head.we). Entries with we=0 retire without using the write port.
//  Latency: a push into an empty queue is visible at the head on the next cycle. The queue is strictly in order.
//  Push and pop in the same cycle: count is unchanged, both pointers advance. Pointers wrap modulo DEPTH.
//  Full (count=DEPTH): o_ready=0; i_valid is ignored, and upstream must hold.
//  Empty: o_rf_wr=0, o_rf_waddr=0, o_rf_wdata=0. No pop and no counter change.
//  we = ~(opcode==`B | opcode==`S | rd==0 | misaligned).
//  Data select: `L -> load-extended value; `JAL/`JALR -> i_pc_plus4; otherwise -> i_alu_res.
//  Load extension: the lane is taken from i_mem_rdata at byte i_byte_off (size-aligned).
//   funct3 000 LB: sign-extend 8 bits.     001 LH: sign-extend 16 bits.
//   funct3 100 LBU: zero-extend 8 bits.    101 LHU: zero-extend 16 bits.
//   funct3 010 LW: XLEN=32 passes the word; XLEN=64 sign-extends 32 bits.
//   funct3 110 LWU and 011 LD: XLEN=64 only; LWU zero-extends 32, LD passes 64.
//   Any other funct3, or 110/011 with XLEN=32: treated as misaligned (illegal).
//  Misaligned: LH/LHU with off[0]!=0; LW/LWU with off[1:0]!=0; LD with off!=0.
//   On push of such an entry: we=0, data=0, and o_ld_err is set to 1. It stays set until rst.
//  o_retire_cnt increments by 1 on every pop, including we=0 entries.
//  Holding: while i_rf_ready=0 and head.we=1, all head outputs stay stable.
// TESTING
//  1 Reset then idle -> o_ready=1, o_rf_wr=0, o_retire_cnt=0, o_ld_err=0.
//  2 Push ADD rd=5, alu=0x1234 with i_rf_ready=1 -> next cycle o_rf_wr=1, waddr=5, wdata=0x1234; cnt=1.
//  3 LB, rdata=0x80FF7F00, off=3 -> wdata=0xFFFFFF80. Same with LBU -> 0x00000080. LH, off=2 -> 0xFFFF80FF.
//  4 i_rf_ready=0 with 3 pushes offered (DEPTH=2) -> o_ready=0 after 2 accepted.
//     Raise i_rf_ready -> writes drain in order; the 3rd push is accepted; cnt=3.
//  5 Push BEQ, then SW, then ADD rd=0 -> o_rf_wr never asserted; cnt=3 after 3 cycles.
//     JAL rd=1, pc+4=0x104 -> wdata=0x104.
//  6 LW, off=2 -> no write and o_ld_err=1. Assert rst while the queue is full -> empty, cnt=0, o_ld_err=0.

Source files
------------

// File: rtl/wb_commit_queue.sv
// wb_commit_queue: writeback formatter feeding an in-order DEPTH-entry queue that drains
// through a back-pressurable register-file write port, with retire counter and sticky load error.
module wb_commit_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_funct3,
    input  logic [4:0]       i_rd,
    input  logic [XLEN-1:0]  i_alu_res,
    input  logic [XLEN-1:0]  i_mem_rdata,
    input  logic [2:0]       i_byte_off,
    input  logic [XLEN-1:0]  i_pc_plus4,
    output logic             o_rf_wr,
    output logic [4:0]       o_rf_waddr,
    output logic [XLEN-1:0]  o_rf_wdata,
    input  logic             i_rf_ready,
    output logic [CNT_W-1:0] o_retire_cnt,
    output logic             o_ld_err
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic IS32 = (XLEN == 32);

    logic [63:0]      w_raw;
    logic [63:0]      w_lane;
    logic [63:0]      w_ext;
    logic [2:0]       w_off;
    logic             w_mis;
    logic             w_is_load;
    logic             w_bad;
    logic             w_we;
    logic [XLEN-1:0]  w_data;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;

    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [PW:0]      r_count;
    logic [CNT_W-1:0] r_retire;
    logic             r_ld_err;
    logic             r_we   [DEPTH];
    logic [4:0]       r_rd   [DEPTH];
    logic [XLEN-1:0]  r_data [DEPTH];

    // Load formatting is done at 64 bits and truncated, so one path serves both XLEN values.
    assign w_off  = IS32 ? {1'b0, i_byte_off[1:0]} : i_byte_off;
    assign w_raw  = 64'(i_mem_rdata);
    assign w_lane = w_raw >> {w_off, 3'b000};

    always_comb begin
        w_ext = '0;
        w_mis = 1'b0;
        case (i_funct3)
            3'b000: w_ext = {{56{w_lane[7]}}, w_lane[7:0]};
            3'b100: w_ext = {56'd0, w_lane[7:0]};
            3'b001: begin
                w_ext = {{48{w_lane[15]}}, w_lane[15:0]};
                w_mis = w_off[0];
            end
            3'b101: begin
                w_ext = {48'd0, w_lane[15:0]};
                w_mis = w_off[0];
            end
            3'b010: begin
                w_ext = {{32{w_lane[31]}}, w_lane[31:0]};
                w_mis = |w_off[1:0];
            end
            3'b110: begin
                w_ext = {32'd0, w_lane[31:0]};
                w_mis = IS32 | (|w_off[1:0]);
            end
            3'b011: begin
                w_ext = w_lane;
                w_mis = IS32 | (|w_off);
            end
            default: w_mis = 1'b1;
        endcase
    end

    assign w_is_load = (i_opcode == OP_L);
    assign w_bad     = w_is_load & w_mis;
    assign w_we      = ~((i_opcode == OP_B) | (i_opcode == OP_S) | (i_rd == 5'd0) | w_bad);
    assign w_data    = w_bad ? '0 :
                       w_is_load ? w_ext[XLEN-1:0] :
                       ((i_opcode == OP_JAL) | (i_opcode == OP_JALR)) ? i_pc_plus4 : i_alu_res;

    assign w_empty = (r_count == '0);
    assign o_ready = (r_count < (PW+1)'(DEPTH));
    assign w_push  = i_valid & o_ready;
    // Non-writing entries retire without needing the shared port.
    assign w_pop   = ~w_empty & (i_rf_ready | ~r_we[r_rp]);

    assign o_rf_wr      = ~w_empty & r_we[r_rp];
    assign o_rf_waddr   = w_empty ? '0 : r_rd[r_rp];
    assign o_rf_wdata   = w_empty ? '0 : r_data[r_rp];
    assign o_retire_cnt = r_retire;
    assign o_ld_err     = r_ld_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_count  <= '0;
            r_retire <= '0;
            r_ld_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PW'(1);
                if (w_bad) r_ld_err <= 1'b1;
            end
            if (w_pop) begin
                r_rp     <= r_rp + PW'(1);
                r_retire <= r_retire + CNT_W'(1);
            end
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_we[r_wp]   <= w_we;
            r_rd[r_wp]   <= i_rd;
            r_data[r_wp] <= w_data;
        end
    end
endmodule
